ha3: RTL and testbench

Sequential signed integer divider with a four-phase REQ/ACK handshake. It accepts a 16-bit two's-complement dividend A and divisor D and produces quotient Q and remainder R after a fixed multi-cycle latency. Divide-by-zero is flagged immediately via FDBZ. It sits as a slave arithmetic unit behind any requester that drives REQ and waits for ACK.

---
 rtl/ha3_pkg.sv | 18 +
 rtl/ha3_udiv_step.sv | 23 ++
 rtl/ha3.sv | 107 ++++++++++
 tb/tb_ha3.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ha3_pkg.sv
// Shared types and sizing for the ha3 signed sequential divider.
package ha3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/ha3_udiv_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module ha3_udiv_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < dmag <= 2^(WIDTH-1), so the extra bit of diff is a reliable sign.
  always_comb begin
    shifted  = {rem, din};
    diff     = shifted - {1'b0, dmag};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/ha3.sv
// Signed sequential divider behind a four-phase REQ/ACK handshake.
//   state | meaning
//   IDLE  | waiting for REQ; ACK low
//   BUSY  | one restoring step per edge, WIDTH steps, then finalize
//   DONE  | result valid, ACK high until REQ drops
module ha3
  import ha3_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] D,
  output logic             ACK,
  output logic             FDBZ,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dmag;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  // quo starts as |A| and shifts left each step, collecting quotient bits at the LSB.
  ha3_udiv_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .din      (quo[WIDTH-1]),
    .dmag     (dmag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dmag  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ACK   <= 1'b0;
      FDBZ  <= 1'b0;
      Q     <= '0;
      R     <= '0;
    end else begin
      case (state)
        IDLE: begin
          ACK <= 1'b0;
          if (REQ) begin
            FDBZ <= 1'b0;
            if (D == '0) begin
              FDBZ  <= 1'b1;
              ACK   <= 1'b1;
              Q     <= '0;
              R     <= '0;
              state <= DONE;
            end else begin
              quo   <= A[WIDTH-1] ? (~A + 1'b1) : A;
              dmag  <= D[WIDTH-1] ? (~D + 1'b1) : D;
              neg_q <= A[WIDTH-1] ^ D[WIDTH-1];
              neg_r <= A[WIDTH-1];
              rem   <= '0;
              cnt   <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!REQ) begin
            state <= IDLE;
          end else if (cnt == CNT_W'(WIDTH)) begin
            Q     <= neg_q ? (~quo + 1'b1) : quo;
            R     <= neg_r ? (~rem + 1'b1) : rem;
            ACK   <= 1'b1;
            state <= DONE;
          end else begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], q_bit};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!REQ) begin
            ACK   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ACK   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ha3.sv
// Self-checking bench for ha3: directed corner cases plus random operands vs. an integer model.
module tb_ha3;

  logic        clk;
  logic        rst;
  logic        req;
  logic [15:0] a;
  logic [15:0] d;
  logic        ack;
  logic        fdbz;
  logic [15:0] q;
  logic [15:0] r;

  int checks   = 0;
  int failures = 0;

  logic [15:0] last_q;
  logic [15:0] last_r;
  logic        last_fdbz;

  ha3 #(.WIDTH(16)) dut (
    .CLK  (clk),
    .RST  (rst),
    .REQ  (req),
    .A    (a),
    .D    (d),
    .ACK  (ack),
    .FDBZ (fdbz),
    .Q    (q),
    .R    (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero, remainder takes the dividend's sign.
  task automatic model(input logic [15:0] av, input logic [15:0] dv,
                       output logic [15:0] eq, output logic [15:0] er);
    int ai;
    int di;
    int qi;
    int ri;
    ai = int'($signed(av));
    di = int'($signed(dv));
    qi = ai / di;
    ri = ai % di;
    eq = qi[15:0];
    er = ri[15:0];
  endtask

  task automatic run_div(input string tag, input logic [15:0] av, input logic [15:0] dv);
    logic [15:0] eq;
    logic [15:0] er;
    logic        early;
    req = 1'b1;
    a   = av;
    d   = dv;
    tick();
    a = 16'($urandom);
    d = 16'($urandom);
    if (dv == 16'h0) begin
      chk({tag, "_dbz_ack"},  ack,  1'b1);
      chk({tag, "_dbz_flag"}, fdbz, 1'b1);
      chk({tag, "_dbz_q"},    q,    16'h0);
      chk({tag, "_dbz_r"},    r,    16'h0);
      last_q = 16'h0; last_r = 16'h0; last_fdbz = 1'b1;
    end else begin
      model(av, dv, eq, er);
      early = 1'b0;
      for (int i = 1; i <= 16; i++) begin
        tick();
        if (ack !== 1'b0) early = 1'b1;
      end
      chk({tag, "_ack_early"}, early, 1'b0);
      tick();
      chk({tag, "_ack"},  ack,  1'b1);
      chk({tag, "_fdbz"}, fdbz, 1'b0);
      chk({tag, "_q"},    q,    eq);
      chk({tag, "_r"},    r,    er);
      tick();
      chk({tag, "_hold"}, {ack, q, r}, {1'b1, eq, er});
      last_q = eq; last_r = er; last_fdbz = 1'b0;
    end
    req = 1'b0;
    tick();
    chk({tag, "_ackdrop"}, ack, 1'b0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rd;
    logic        saw_ack;
    rst = 1'b1; req = 1'b0; a = 16'h1234; d = 16'h5678;
    last_q = 16'h0; last_r = 16'h0; last_fdbz = 1'b0;
    tick();
    chk("reset", {ack, fdbz, q, r}, 34'h0);
    rst = 1'b0;
    tick();

    run_div("9_2",    16'h0009, 16'h0002);
    run_div("9_m2",   16'h0009, 16'hFFFE);
    run_div("m9_2",   16'hFFF7, 16'h0002);
    run_div("dbz",    16'h0009, 16'h0000);
    chk("dbz_flag_kept", fdbz, 1'b1);

    // Accept edge clears FDBZ immediately for a non-zero divisor.
    req = 1'b1; a = 16'h0064; d = 16'h0007;
    tick();
    chk("fdbz_clear_on_accept", fdbz, 1'b0);
    req = 1'b0;
    tick();

    run_div("ovf",    16'h8000, 16'hFFFF);
    run_div("max_1",  16'h7FFF, 16'h0001);
    run_div("3_7",    16'h0003, 16'h0007);
    run_div("min_min",16'h8000, 16'h8000);
    run_div("m1_min", 16'hFFFF, 16'h8000);

    // Abort: REQ drops before edge 5 of a division.
    req = 1'b1; a = 16'h1000; d = 16'h0003;
    tick();
    for (int i = 1; i <= 4; i++) tick();
    req = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (ack !== 1'b0) saw_ack = 1'b1;
    end
    chk("abort_ack", saw_ack, 1'b0);
    chk("abort_keep", {fdbz, q, r}, {last_fdbz, last_q, last_r});

    // Reset at edge 8 of a division, then a normal request.
    req = 1'b1; a = 16'h7000; d = 16'h0005;
    tick();
    for (int i = 1; i <= 7; i++) tick();
    rst = 1'b1;
    tick();
    chk("midreset", {ack, fdbz, q, r}, 34'h0);
    rst = 1'b0; req = 1'b0;
    tick();
    run_div("after_rst", 16'h7000, 16'h0005);

    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rd = 16'($urandom_range(1, 15));
        1:       rd = 16'(-$signed(17'($urandom_range(1, 15))));
        2:       rd = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        default: rd = 16'($urandom);
      endcase
      run_div("rand", ra, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
